// File: rtl/mem_trace_buffer.sv
// mem_trace_buffer: clocked memory-access tracer.
// Read/write events from the LSU are filtered by an address window and tagged
// with a wrapping sequence number. They are then queued in a small FIFO that
// drains through a ready/valid port. Any event lost to a full FIFO still
// consumes its sequence number, so a gap in out_seq shows where events were
// lost. drop_cnt and overflow also count the loss.
module mem_trace_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic [ADDR_W-1:0]          filt_lo,
  input  logic [ADDR_W-1:0]          filt_hi,
  input  logic                       rd_valid,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic [LEN_W-1:0]           rd_len,
  input  logic [DATA_W-1:0]          rd_data,
  input  logic                       wr_valid,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [LEN_W-1:0]           wr_len,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_is_wr,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [LEN_W-1:0]           out_len,
  output logic [DATA_W-1:0]          out_data,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                drop_cnt,
  output logic                       overflow,
  input  logic                       clr_drop
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int ENT_W = 1 + ADDR_W + LEN_W + DATA_W + SEQ_W;

  // Entry layout: {is_wr, addr, len, data, seq}
  logic [ENT_W-1:0] mem [DEPTH];

  logic [PW-1:0]    wp, rp;
  logic [SEQ_W-1:0] seq_cnt;

  logic             acc_rd, acc_wr;
  logic [CW-1:0]    free_c;
  logic             push0, push1;
  logic [1:0]       n_drop;
  logic [1:0]       n_acc;
  logic [1:0]       n_push;
  logic             pop;
  logic [ENT_W-1:0] slot0, slot1;
  logic [ENT_W-1:0] head;
  logic [15:0]      drop_base;
  logic [16:0]      drop_sum;

  // An empty window (filt_lo > filt_hi) falls out of the two compares naturally.
  assign acc_rd = en && rd_valid && (rd_addr >= filt_lo) && (rd_addr <= filt_hi);
  assign acc_wr = en && wr_valid && (wr_addr >= filt_lo) && (wr_addr <= filt_hi);

  // Space is judged on the registered count; a same-cycle pop does not free a slot.
  assign free_c = CW'(DEPTH) - count;
  assign pop    = (count != '0) && out_ready;

  assign n_acc  = {1'b0, acc_rd} + {1'b0, acc_wr};
  assign n_push = {1'b0, push0} + {1'b0, push1};

  // Slot 0 holds the first accepted event (the read when both fire); slot 1 is
  // only ever the write of a read+write pair.
  assign slot0 = acc_rd ? {1'b0, rd_addr, rd_len, rd_data, seq_cnt}
                        : {1'b1, wr_addr, wr_len, wr_data, seq_cnt};
  assign slot1 = {1'b1, wr_addr, wr_len, wr_data, seq_cnt + SEQ_W'(1)};

  // Decide how many accepted events fit and how many are dropped.
  always_comb begin
    push0  = 1'b0;
    push1  = 1'b0;
    n_drop = 2'd0;
    if (acc_rd && acc_wr) begin
      if (free_c >= CW'(2)) begin
        push0 = 1'b1;
        push1 = 1'b1;
      end else if (free_c == CW'(1)) begin
        push0  = 1'b1;
        n_drop = 2'd1;
      end else begin
        n_drop = 2'd2;
      end
    end else if (acc_rd || acc_wr) begin
      if (free_c != '0) push0 = 1'b1;
      else              n_drop = 2'd1;
    end
  end

  // A drop in the same cycle as a clear wins: the count restarts from the drops.
  assign drop_base = clr_drop ? 16'd0 : drop_cnt;
  assign drop_sum  = {1'b0, drop_base} + 17'(n_drop);

  // Entry storage; contents need no reset because out_* are gated by out_valid.
  always_ff @(posedge clock) begin
    if (push0) mem[wp] <= slot0;
    if (push1) mem[wp + PW'(1)] <= slot1;
  end

  // Pointers, occupancy and sequence counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      seq_cnt <= '0;
    end else begin
      wp      <= wp + PW'(n_push);
      if (pop) rp <= rp + PW'(1);
      count   <= count + CW'(n_push) - CW'(pop);
      seq_cnt <= seq_cnt + SEQ_W'(n_acc);
    end
  end

  // Drop counter (saturating) and sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt <= 16'd0;
      overflow <= 1'b0;
    end else if (n_drop != 2'd0) begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      overflow <= 1'b1;
    end else if (clr_drop) begin
      drop_cnt <= 16'd0;
      overflow <= 1'b0;
    end
  end

  assign out_valid = (count != '0);
  assign head      = mem[rp];
  assign {out_is_wr, out_addr, out_len, out_data, out_seq} = out_valid ? head : '0;

endmodule
